apb_arb_master: RTL and testbench
=================================

# apb_arb_master

Two-requester APB master that sequences accesses to a shared APB slave (the register-file slaves on the local APB segment). Accepts simple request/grant commands from two internal requesters, arbitrates round-robin, drives the APB SETUP/ACCESS protocol including wait states, and returns read data and error status to the winning requester.

## Interface
- ADDR_W, 16, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before forced abort (only with the timeout feature)

- iPCLK  in  1  clock, rising edge
- iPRESETn  in  1  reset, asynchronous, active-low
- iREQ0 / iREQ1  in  1  request, held high until granted
- iWRITE0 / iWRITE1  in  1  1 = write, 0 = read
- iADDR0 / iADDR1  in  ADDR_W  transfer address
- iWDATA0 / iWDATA1  in  DATA_W  write data
- iSTRB0 / iSTRB1  in  DATA_W/8  write byte strobes
- oGNT0 / oGNT1  out  1  one-cycle pulse: command accepted this cycle
- oDONE0 / oDONE1  out  1  one-cycle pulse: transfer complete, oRDATA/oERR valid
- oRDATA  out  DATA_W  read data of completed transfer
- oERR  out  1  error status of completed transfer
- oPSEL, oPENABLE, oPWRITE  out  1  APB control
- oPADDR  out  ADDR_W; oPWDATA  out  DATA_W; oPSTRB  out  DATA_W/8
- iPRDATA  in  DATA_W; iPREADY  in  1; iPSLVERR  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any iREQn high, arbiter selects one; oGNTn high combinationally in that cycle; command (write, addr, wdata, strb, requester id) latched at the edge; next state SETUP. No request: stay IDLE.
- Arbitration: round-robin pointer; on simultaneous requests the non-last-granted requester wins. Pointer resets to favour requester 0. Single request always wins immediately.
- SETUP: oPSEL=1, oPENABLE=0, address/control/data from latched command; unconditionally -> ACCESS.
- ACCESS: oPSEL=1, oPENABLE=1; stay while iPREADY=0; on iPREADY=1 capture iPRDATA (reads; 0 for writes) into oRDATA and iPSLVERR into oERR, -> IDLE.
- In the IDLE cycle after completion, oDONEn (latched id) pulses; a new grant may occur in that same cycle.
- oPADDR/oPWRITE/oPWDATA/oPSTRB hold last values in IDLE; oPSTRB forced 0 for reads.
- oRDATA/oERR hold until next completion.
- Requester must keep command inputs stable while iREQn high and not yet granted; after oGNTn, inputs may change.
- Reset mid-transfer: transfer discarded, no oDONE, FSM -> IDLE.

## Timing
- Reset values: oGNTn=0, oDONEn=0, oRDATA=0, oERR=0, oPSEL=0, oPENABLE=0, oPWRITE=0, oPADDR=0, oPWDATA=0, oPSTRB=0; state IDLE.
- Zero-wait transfer: grant cycle T, SETUP T+1, ACCESS T+2, oDONE T+3. Each slave wait state adds one cycle.
- Minimum issue interval: 3 cycles (back-to-back grants at T and T+3).
- oPSEL/oPENABLE registered, glitch-free; oGNTn combinational from iREQn in IDLE.

## Configuration
- APB_TIMEOUT_EN defined: counter increments each ACCESS cycle with iPREADY=0; when it reaches TIMEOUT_CYCLES, oPSEL/oPENABLE drop, FSM -> IDLE, oDONEn pulses with oERR=1, oRDATA=0. Counter clears on entering ACCESS.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for iPREADY. TIMEOUT_CYCLES unused.

## Structure
- Package apb_arb_pkg: FSM state enum (IDLE/SETUP/ACCESS), default ADDR_W/DATA_W constants, timeout counter width derived from TIMEOUT_CYCLES.
- Sub-module rr_arb2: two-way round-robin arbiter (req[1:0], advance strobe -> one-hot gnt, pointer register); top holds FSM, command latch, response registers.

## Test plan
- Reset, single write from requester 0 to 0x0004 data 0xDEADBEEF strb 0xF, iPREADY=1 -> oGNT0 at T, PSEL/PENABLE SETUP T+1 / ACCESS T+2, oDONE0 at T+3, oERR=0.
- Read from requester 1 to 0x0004, slave returns 0xDEADBEEF with 2 wait states -> ACCESS held 3 cycles, oDONE1 at T+5, oRDATA=0xDEADBEEF.
- iREQ0 and iREQ1 both held continuously -> grants alternate 0,1,0,1 every 3 cycles starting with 0.
- Write with iPSLVERR=1 in ACCESS -> oDONE with oERR=1; next transfer oERR=0.
- iPRESETn low during ACCESS -> all outputs 0 asynchronously, no oDONE, next request served normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, iPREADY stuck 0 -> PSEL drops after 16 ACCESS cycles, oDONE with oERR=1, oRDATA=0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB master.
// Holds the transfer FSM state enum, default bus widths and the width of the
// optional ACCESS timeout counter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int ADDR_W_DEF         = 16;
  localparam int DATA_W_DEF         = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // The counter only ever holds 0 .. cycles-1 before the abort fires.
  function automatic int to_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int TO_CNT_W_DEF = to_cnt_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/apb_arb_master_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from a 2-bit request vector.
// Latency: grant is combinational from req_i; pointer moves on the edge where adv_i is high.
// Backpressure: none; the caller decides via adv_i whether a grant is consumed.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i[1:0]     requests
//   adv_i          grant is being taken this cycle; rotate priority
//   gnt_o[1:0]     one-hot grant (0 when no request)
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 1 means requester 1 wins a tie; resets to favour requester 0.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // After serving requester 0 the tie goes to 1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration, APB SETUP/ACCESS sequencing, response return.
// Latency: grant cycle T, SETUP T+1, ACCESS T+2.., done pulse one cycle after the PREADY cycle.
// Backpressure: requesters hold iREQn until oGNTn; slave stalls via iPREADY (bounded only with APB_TIMEOUT_EN).
//
// Ports:
//   iPCLK, iPRESETn                  clock, asynchronous active-low reset
//   iREQn/iWRITEn/iADDRn/iWDATAn/iSTRBn  command from requester n (n = 0, 1)
//   oGNTn                            command accepted this cycle (combinational)
//   oDONEn, oRDATA, oERR             completion pulse and its response
//   oPSEL..oPSTRB, iPRDATA/iPREADY/iPSLVERR  APB master side
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES stalled cycles).
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                iPCLK,
  input  logic                iPRESETn,
  input  logic                iREQ0,
  input  logic                iREQ1,
  input  logic                iWRITE0,
  input  logic                iWRITE1,
  input  logic [ADDR_W-1:0]   iADDR0,
  input  logic [ADDR_W-1:0]   iADDR1,
  input  logic [DATA_W-1:0]   iWDATA0,
  input  logic [DATA_W-1:0]   iWDATA1,
  input  logic [DATA_W/8-1:0] iSTRB0,
  input  logic [DATA_W/8-1:0] iSTRB1,
  output logic                oGNT0,
  output logic                oGNT1,
  output logic                oDONE0,
  output logic                oDONE1,
  output logic [DATA_W-1:0]   oRDATA,
  output logic                oERR,
  output logic                oPSEL,
  output logic                oPENABLE,
  output logic                oPWRITE,
  output logic [ADDR_W-1:0]   oPADDR,
  output logic [DATA_W-1:0]   oPWDATA,
  output logic [DATA_W/8-1:0] oPSTRB,
  input  logic [DATA_W-1:0]   iPRDATA,
  input  logic                iPREADY,
  input  logic                iPSLVERR
);

  localparam int STRB_W = DATA_W / 8;

  apb_state_e state_q, state_d;

  logic [1:0] arb_gnt;
  logic       grant_en;
  logic       take;

  // Latched command doubles as the APB address/control/data registers, so
  // these hold their last values through IDLE without extra storage.
  logic              cmd_id_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              to_hit;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_strb;

  // Grants are only offered in IDLE; the reset term keeps oGNTn low while
  // reset is asserted even if a request is already pending.
  assign grant_en = (state_q == IDLE) && iPRESETn;

  rr_arb2 u_arb (
    .clk_i  (iPCLK),
    .rst_ni (iPRESETn),
    .req_i  ({iREQ1, iREQ0}),
    .adv_i  (grant_en),
    .gnt_o  (arb_gnt)
  );

  assign take  = grant_en && (arb_gnt != 2'b00);
  assign oGNT0 = grant_en && arb_gnt[0];
  assign oGNT1 = grant_en && arb_gnt[1];

  assign sel_write = arb_gnt[1] ? iWRITE1 : iWRITE0;
  assign sel_addr  = arb_gnt[1] ? iADDR1  : iADDR0;
  assign sel_wdata = arb_gnt[1] ? iWDATA1 : iWDATA0;
  assign sel_strb  = arb_gnt[1] ? iSTRB1  : iSTRB0;

`ifdef APB_TIMEOUT_EN
  localparam int CntW = to_cnt_w(TIMEOUT_CYCLES);
  logic [CntW-1:0] to_cnt_q, to_cnt_d;

  // Fires on the last permitted stalled ACCESS cycle, so ACCESS lasts
  // exactly TIMEOUT_CYCLES cycles when PREADY never arrives.
  assign to_hit = (state_q == ACCESS) && !iPREADY &&
                  (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == SETUP) begin
      to_cnt_d = '0;
    end else if ((state_q == ACCESS) && !iPREADY) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_hit = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (iPREADY || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. PSEL/PENABLE are decoded from the next state and
  // registered, so the pins come straight from flops.
  always_comb begin
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    if ((state_q == ACCESS) && iPREADY) begin
      done_d  = 1'b1;
      rdata_d = pwrite_q ? '0 : iPRDATA;
      err_d   = iPSLVERR;
    end else if (to_hit) begin
      done_d  = 1'b1;
      rdata_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cmd_id_q  <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (take) begin
        cmd_id_q <= arb_gnt[1];
        pwrite_q <= sel_write;
        paddr_q  <= sel_addr;
        pwdata_q <= sel_wdata;
        pstrb_q  <= sel_write ? sel_strb : '0;
      end
    end
  end

  // cmd_id_q is still the finished transfer's id during the done cycle:
  // a new grant in that cycle only overwrites it at the following edge.
  assign oDONE0   = done_q && !cmd_id_q;
  assign oDONE1   = done_q &&  cmd_id_q;
  assign oRDATA   = rdata_q;
  assign oERR     = err_q;
  assign oPSEL    = psel_q;
  assign oPENABLE = penable_q;
  assign oPWRITE  = pwrite_q;
  assign oPADDR   = paddr_q;
  assign oPWDATA  = pwdata_q;
  assign oPSTRB   = pstrb_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master: directed scenarios plus a randomized
// run scored against a transaction-level model (grant cycle, wait count, done cycle).
module tb_apb_arb_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          iPCLK = 1'b0;
  logic          iPRESETn = 1'b0;
  logic          iREQ0 = 1'b0, iREQ1 = 1'b0;
  logic          iWRITE0 = 1'b0, iWRITE1 = 1'b0;
  logic [AW-1:0] iADDR0 = '0, iADDR1 = '0;
  logic [DW-1:0] iWDATA0 = '0, iWDATA1 = '0;
  logic [SW-1:0] iSTRB0 = '0, iSTRB1 = '0;
  logic          oGNT0, oGNT1, oDONE0, oDONE1;
  logic [DW-1:0] oRDATA;
  logic          oERR, oPSEL, oPENABLE, oPWRITE;
  logic [AW-1:0] oPADDR;
  logic [DW-1:0] oPWDATA;
  logic [SW-1:0] oPSTRB;
  logic [DW-1:0] iPRDATA = '0;
  logic          iPREADY = 1'b0;
  logic          iPSLVERR = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 iPCLK = ~iPCLK;

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .iPCLK(iPCLK), .iPRESETn(iPRESETn),
    .iREQ0(iREQ0), .iREQ1(iREQ1), .iWRITE0(iWRITE0), .iWRITE1(iWRITE1),
    .iADDR0(iADDR0), .iADDR1(iADDR1), .iWDATA0(iWDATA0), .iWDATA1(iWDATA1),
    .iSTRB0(iSTRB0), .iSTRB1(iSTRB1),
    .oGNT0(oGNT0), .oGNT1(oGNT1), .oDONE0(oDONE0), .oDONE1(oDONE1),
    .oRDATA(oRDATA), .oERR(oERR),
    .oPSEL(oPSEL), .oPENABLE(oPENABLE), .oPWRITE(oPWRITE),
    .oPADDR(oPADDR), .oPWDATA(oPWDATA), .oPSTRB(oPSTRB),
    .iPRDATA(iPRDATA), .iPREADY(iPREADY), .iPSLVERR(iPSLVERR)
  );

  // Slave model: each transfer consumes one scripted response (wait states, error, read data).
  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } slv_rsp_t;

  slv_rsp_t slv_q[$];
  slv_rsp_t slv_cur;
  int       slv_left = 0;

  always begin
    @(posedge iPCLK);
    #2;
    if (oPSEL && !oPENABLE) begin
      if (slv_q.size() > 0) slv_cur = slv_q.pop_front();
      else slv_cur = '{0, 1'b0, 32'h0};
      slv_left = slv_cur.waits;
      iPREADY  = 1'b0;
      iPSLVERR = 1'b0;
    end else if (oPSEL && oPENABLE) begin
      if (slv_left > 0) begin
        slv_left--;
        iPREADY  = 1'b0;
        iPSLVERR = 1'b0;
      end else begin
        iPREADY  = 1'b1;
        iPSLVERR = slv_cur.err;
        iPRDATA  = slv_cur.rdata;
      end
    end else begin
      iPREADY  = 1'b0;
      iPSLVERR = 1'b0;
    end
  end

  task automatic tick();
    @(posedge iPCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge iPCLK);
  endtask

  task automatic set_req(input int id, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (id == 0) begin
      iREQ0 = 1'b1; iWRITE0 = w; iADDR0 = a; iWDATA0 = d; iSTRB0 = s;
    end else begin
      iREQ1 = 1'b1; iWRITE1 = w; iADDR1 = a; iWDATA1 = d; iSTRB1 = s;
    end
  endtask

  task automatic test_reset();
    iPRESETn = 1'b0;
    iREQ0 = 1'b1;
    smp(); smp();
    checks++; if ({oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oPSTRB} !== '0) begin
      failures++; $display("FAIL reset_apb: got sel=%b en=%b wr=%b addr=%h wdata=%h strb=%h want all 0",
        oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oPSTRB); end
    checks++; if ({oGNT1, oGNT0, oDONE1, oDONE0} !== 4'b0000) begin
      failures++; $display("FAIL reset_pulses: got gnt=%b%b done=%b%b want 0000", oGNT1, oGNT0, oDONE1, oDONE0); end
    checks++; if ({oRDATA, oERR} !== '0) begin
      failures++; $display("FAIL reset_resp: got rdata=%h err=%b want 0/0", oRDATA, oERR); end
    iREQ0 = 1'b0;
    tick();
    iPRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    slv_q.push_back('{0, 1'b0, 32'h0});
    set_req(0, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
    smp();
    checks++; if ({oGNT1, oGNT0, oPSEL} !== 3'b010) begin
      failures++; $display("FAIL wr_grant: got gnt=%b%b sel=%b want gnt=01 sel=0", oGNT1, oGNT0, oPSEL); end
    tick();
    iREQ0 = 1'b0; iWDATA0 = 32'h0; iADDR0 = 16'hFFFF;
    smp();
    checks++; if ({oPSEL, oPENABLE, oGNT0} !== 3'b100) begin
      failures++; $display("FAIL wr_setup: got sel=%b en=%b gnt0=%b want 1 0 0", oPSEL, oPENABLE, oGNT0); end
    checks++; if ({oPWRITE, oPADDR, oPWDATA, oPSTRB} !== {1'b1, 16'h0004, 32'hDEADBEEF, 4'hF}) begin
      failures++; $display("FAIL wr_setup_bus: got wr=%b addr=%h wdata=%h strb=%h want 1 0004 deadbeef f",
        oPWRITE, oPADDR, oPWDATA, oPSTRB); end
    tick(); smp();
    checks++; if ({oPSEL, oPENABLE, oDONE0} !== 3'b110) begin
      failures++; $display("FAIL wr_access: got sel=%b en=%b done0=%b want 1 1 0", oPSEL, oPENABLE, oDONE0); end
    tick(); smp();
    checks++; if ({oDONE1, oDONE0, oERR, oPSEL, oPENABLE} !== 5'b01000) begin
      failures++; $display("FAIL wr_done: got done=%b%b err=%b sel=%b en=%b want 01 0 0 0",
        oDONE1, oDONE0, oERR, oPSEL, oPENABLE); end
    checks++; if (oPADDR !== 16'h0004) begin
      failures++; $display("FAIL wr_addr_hold: got %h want 0004", oPADDR); end
    tick(); smp();
    checks++; if ({oDONE1, oDONE0} !== 2'b00) begin
      failures++; $display("FAIL wr_done_pulse: got %b%b want 00", oDONE1, oDONE0); end
    tick();
  endtask

  task automatic test_read_wait();
    slv_q.push_back('{2, 1'b0, 32'hDEADBEEF});
    set_req(1, 1'b0, 16'h0004, 32'h12345678, 4'hF);
    smp();
    checks++; if ({oGNT1, oGNT0} !== 2'b10) begin
      failures++; $display("FAIL rd_grant: got %b%b want 10", oGNT1, oGNT0); end
    tick();
    iREQ1 = 1'b0;
    smp();
    checks++; if ({oPSEL, oPENABLE, oPWRITE, oPSTRB} !== {3'b100, 4'h0}) begin
      failures++; $display("FAIL rd_setup: got sel=%b en=%b wr=%b strb=%h want 1 0 0 0",
        oPSEL, oPENABLE, oPWRITE, oPSTRB); end
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      checks++; if ({oPSEL, oPENABLE, oDONE1, oDONE0} !== 4'b1100) begin
        failures++; $display("FAIL rd_access%0d: got sel=%b en=%b done=%b%b want 1 1 00",
          k, oPSEL, oPENABLE, oDONE1, oDONE0); end
    end
    tick(); smp();
    checks++; if ({oDONE1, oDONE0, oPSEL} !== 3'b100) begin
      failures++; $display("FAIL rd_done: got done=%b%b sel=%b want 10 0", oDONE1, oDONE0, oPSEL); end
    checks++; if ({oRDATA, oERR} !== {32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL rd_data: got rdata=%h err=%b want deadbeef 0", oRDATA, oERR); end
    tick(); smp();
    checks++; if (oRDATA !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_data_hold: got %h want deadbeef", oRDATA); end
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] exp;
    for (int k = 0; k < 4; k++) slv_q.push_back('{0, 1'b0, 32'h0});
    set_req(0, 1'b1, 16'h0100, 32'h11111111, 4'h3);
    set_req(1, 1'b1, 16'h0200, 32'h22222222, 4'hC);
    for (int c = 0; c < 12; c++) begin
      smp();
      exp = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if ({oGNT1, oGNT0} !== exp) begin
        failures++; $display("FAIL alt_grant c%0d: got %b%b want %b", c, oGNT1, oGNT0, exp); end
      tick();
    end
    iREQ0 = 1'b0; iREQ1 = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_slverr();
    slv_q.push_back('{1, 1'b1, 32'h0});
    set_req(0, 1'b1, 16'h0008, 32'hCAFEF00D, 4'hF);
    tick(); iREQ0 = 1'b0;
    tick(); tick(); smp();
    checks++; if ({oDONE1, oDONE0} !== 2'b00) begin
      failures++; $display("FAIL err_early: got done=%b%b want 00", oDONE1, oDONE0); end
    tick(); smp();
    checks++; if ({oDONE1, oDONE0, oERR} !== 3'b011) begin
      failures++; $display("FAIL err_done: got done=%b%b err=%b want 01 1", oDONE1, oDONE0, oERR); end
    tick();
    slv_q.push_back('{0, 1'b0, 32'h0BADF00D});
    set_req(0, 1'b0, 16'h000C, 32'h0, 4'hF);
    tick(); iREQ0 = 1'b0;
    tick(); tick(); smp();
    checks++; if ({oDONE1, oDONE0, oERR, oRDATA} !== {3'b010, 32'h0BADF00D}) begin
      failures++; $display("FAIL err_clear: got done=%b%b err=%b rdata=%h want 01 0 0badf00d",
        oDONE1, oDONE0, oERR, oRDATA); end
    tick();
  endtask

  task automatic test_reset_mid();
    slv_q.push_back('{5, 1'b0, 32'hAAAA5555});
    set_req(1, 1'b0, 16'h0040, 32'h0, 4'h0);
    tick(); iREQ1 = 1'b0;
    tick(); smp();
    checks++; if ({oPSEL, oPENABLE} !== 2'b11) begin
      failures++; $display("FAIL rst_mid_access: got sel=%b en=%b want 1 1", oPSEL, oPENABLE); end
    #1 iPRESETn = 1'b0;
    #1;
    checks++; if ({oPSEL, oPENABLE, oPWRITE, oPADDR, oRDATA, oERR, oGNT0, oGNT1, oDONE0, oDONE1} !== '0) begin
      failures++; $display("FAIL rst_mid_async: got sel=%b en=%b addr=%h rdata=%h err=%b want all 0",
        oPSEL, oPENABLE, oPADDR, oRDATA, oERR); end
    tick(); tick();
    iPRESETn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp();
      checks++; if ({oDONE1, oDONE0, oPSEL} !== 3'b000) begin
        failures++; $display("FAIL rst_mid_quiet%0d: got done=%b%b sel=%b want 00 0", k, oDONE1, oDONE0, oPSEL); end
      tick();
    end
    slv_q.push_back('{0, 1'b0, 32'h0});
    set_req(0, 1'b1, 16'h0010, 32'h5A5A5A5A, 4'h1);
    smp();
    checks++; if ({oGNT1, oGNT0} !== 2'b01) begin
      failures++; $display("FAIL rst_mid_regrant: got %b%b want 01", oGNT1, oGNT0); end
    tick(); iREQ0 = 1'b0;
    tick(); tick(); smp();
    checks++; if ({oDONE1, oDONE0, oERR} !== 3'b010) begin
      failures++; $display("FAIL rst_mid_done: got done=%b%b err=%b want 01 0", oDONE1, oDONE0, oERR); end
    tick();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int n_acc;
    slv_q.push_back('{1000, 1'b0, 32'hFFFFFFFF});
    set_req(0, 1'b0, 16'h0020, 32'h0, 4'h0);
    tick(); iREQ0 = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); smp();
      if (oPSEL && oPENABLE) n_acc++;
      else break;
    end
    checks++; if (n_acc !== 16) begin
      failures++; $display("FAIL to_len: got %0d access cycles want 16", n_acc); end
    checks++; if ({oDONE1, oDONE0, oERR, oRDATA, oPSEL} !== {3'b011, 32'h0, 1'b0}) begin
      failures++; $display("FAIL to_done: got done=%b%b err=%b rdata=%h sel=%b want 01 1 0 0",
        oDONE1, oDONE0, oERR, oRDATA, oPSEL); end
    tick();
  endtask
`endif

  task automatic test_random();
    localparam int NCYC = 400;
    logic          req_on [2];
    logic          r_wr   [2];
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_data [2];
    logic [SW-1:0] r_strb [2];
    int            last, win;
    logic          act;
    int            a_g, a_w, a_id;
    logic          a_wr, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rd;
    logic [SW-1:0] a_strb;
    logic [1:0]    e_gnt, e_sp, e_done;

    iPRESETn = 1'b0;
    tick();
    slv_q.delete();
    iPRESETn = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      req_on[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0; r_strb[i] = '0;
    end
    last = 1; act = 1'b0;
    a_g = 0; a_w = 0; a_id = 0; a_wr = 1'b0; a_err = 1'b0;
    a_addr = '0; a_wdata = '0; a_rd = '0; a_strb = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      smp();
      e_sp = 2'b00;
      if (act && cyc == a_g + 1) e_sp = 2'b10;
      else if (act && cyc >= a_g + 2 && cyc <= a_g + 2 + a_w) e_sp = 2'b11;
      e_done = (act && cyc == a_g + 3 + a_w) ? (a_id == 1 ? 2'b10 : 2'b01) : 2'b00;
      win = -1;
      if (!act || cyc >= a_g + 3 + a_w) begin
        if (req_on[0] && req_on[1]) win = (last == 0) ? 1 : 0;
        else if (req_on[0]) win = 0;
        else if (req_on[1]) win = 1;
      end
      e_gnt = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;

      checks++; if ({oGNT1, oGNT0} !== e_gnt) begin
        failures++; $display("FAIL rnd_gnt c%0d: got %b%b want %b", cyc, oGNT1, oGNT0, e_gnt); end
      checks++; if ({oPSEL, oPENABLE} !== e_sp) begin
        failures++; $display("FAIL rnd_phase c%0d: got sel/en=%b%b want %b", cyc, oPSEL, oPENABLE, e_sp); end
      if (e_sp != 2'b00) begin
        checks++; if ({oPWRITE, oPADDR, oPSTRB} !== {a_wr, a_addr, (a_wr ? a_strb : 4'h0)}) begin
          failures++; $display("FAIL rnd_bus c%0d: got wr=%b addr=%h strb=%h want %b %h %h",
            cyc, oPWRITE, oPADDR, oPSTRB, a_wr, a_addr, a_wr ? a_strb : 4'h0); end
        if (a_wr) begin
          checks++; if (oPWDATA !== a_wdata) begin
            failures++; $display("FAIL rnd_wdata c%0d: got %h want %h", cyc, oPWDATA, a_wdata); end
        end
      end
      checks++; if ({oDONE1, oDONE0} !== e_done) begin
        failures++; $display("FAIL rnd_done c%0d: got %b%b want %b", cyc, oDONE1, oDONE0, e_done); end
      if (e_done != 2'b00) begin
        checks++; if ({oRDATA, oERR} !== {(a_wr ? 32'h0 : a_rd), a_err}) begin
          failures++; $display("FAIL rnd_resp c%0d: got rdata=%h err=%b want %h %b",
            cyc, oRDATA, oERR, a_wr ? 32'h0 : a_rd, a_err); end
      end

      if (win >= 0) begin
        act = 1'b1; a_g = cyc; a_id = win; last = win;
        a_w = int'($urandom_range(0, 3));
        a_err = ($urandom_range(0, 4) == 0);
        a_rd = DW'($urandom);
        a_wr = r_wr[win]; a_addr = r_addr[win]; a_wdata = r_data[win]; a_strb = r_strb[win];
        slv_q.push_back('{a_w, a_err, a_rd});
      end

      tick();
      if (win >= 0) req_on[win] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!req_on[i] && cyc < NCYC - 12 && $urandom_range(0, 2) == 0) begin
          req_on[i] = 1'b1;
          r_wr[i]   = 1'($urandom_range(0, 1));
          r_addr[i] = AW'($urandom);
          r_data[i] = DW'($urandom);
          r_strb[i] = SW'($urandom);
        end
      end
      iREQ0 = req_on[0]; iWRITE0 = r_wr[0]; iADDR0 = r_addr[0]; iWDATA0 = r_data[0]; iSTRB0 = r_strb[0];
      iREQ1 = req_on[1]; iWRITE1 = r_wr[1]; iADDR1 = r_addr[1]; iWDATA1 = r_data[1]; iSTRB1 = r_strb[1];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_alternate();
    test_slverr();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
